// File: rtl/prbs_gen_multi.sv
// prbs_gen_multi: multi-polynomial PRBS generator for the serial link test path.
// It sends comma idle words while stopped, then a fixed-length comma preamble,
// then a parallel PRBS7/15/23/31 stream. The polynomial is latched at run start.
// Optional feature macro: PRBS_ERR_INJECT_EN enables single-word error injection
// (bit 0 flip on an ERROR_IN rising edge) and the ERR_CNT counter.
module prbs_gen_multi #(
  parameter int DATA_W  = 16,
  parameter int PRE_LEN = 8
) (
  input  logic                CLK,
  input  logic                RESETGN,
  input  logic                START,
  input  logic [1:0]          MODE,
  input  logic                ERROR_IN,
  output logic [DATA_W-1:0]   DATA_OUT,
  output logic [DATA_W/8-1:0] CHAR_OUT,
  output logic                RUNNING,
  output logic [31:0]         WORD_CNT,
  output logic [15:0]         ERR_CNT
);

  // K28.5 / K28.1 comma pair, replicated across the word
  localparam logic [DATA_W-1:0] IDLE_WORD = {(DATA_W/16){16'hBC3C}};
  localparam logic [7:0]        PRE_LOAD  = 8'(PRE_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                start_q;
  logic [1:0]          mode_q;
  logic [30:0]         lfsr;
  logic [30:0]         lfsr_next;
  logic [DATA_W-1:0]   prbs_word;
  logic [7:0]          pre_cnt;
  logic                inject;
  logic                run_start;

  // Feedback bit s[N-1] ^ s[T-1] for the selected polynomial
  function automatic logic prbs_fb(input logic [30:0] s, input logic [1:0] sel);
    logic b;
    case (sel)
      2'd0:    b = s[6]  ^ s[5];
      2'd1:    b = s[14] ^ s[13];
      2'd2:    b = s[22] ^ s[17];
      default: b = s[30] ^ s[27];
    endcase
    return b;
  endfunction

  // IDLE -> PREAMBLE edge: latch mode, reseed, clear counters
  assign run_start = (state == ST_IDLE) && (state_next == ST_PRE);

  // Unroll DATA_W serial steps; shifting all 31 bits keeps the low N bits exact
  always_comb begin
    logic [30:0] s;
    logic        b;
    s         = lfsr;
    b         = 1'b0;
    prbs_word = '0;
    for (int i = 0; i < DATA_W; i++) begin
      b            = prbs_fb(s, mode_q);
      prbs_word[i] = b;
      s            = {s[29:0], b};
    end
    lfsr_next = s;
  end

  // Next-state logic: start_q low always returns to IDLE
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start_q) state_next = ST_PRE;
      ST_PRE: begin
        if (!start_q)           state_next = ST_IDLE;
        else if (pre_cnt == '0) state_next = ST_RUN;
      end
      ST_RUN:  if (!start_q) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register and START input stage
  always_ff @(posedge CLK or negedge RESETGN) begin
    if (!RESETGN) begin
      state   <= ST_IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_next;
      start_q <= START;
    end
  end

  // Mode latch, preamble counter and LFSR advance
  always_ff @(posedge CLK or negedge RESETGN) begin
    if (!RESETGN) begin
      mode_q  <= 2'd0;
      pre_cnt <= 8'd0;
      lfsr    <= '1;
    end else if (run_start) begin
      mode_q  <= MODE;
      pre_cnt <= PRE_LOAD;
      lfsr    <= '1;
    end else begin
      if (state == ST_PRE && pre_cnt != '0) pre_cnt <= pre_cnt - 8'd1;
      if (state_next == ST_RUN)             lfsr    <= lfsr_next;
    end
  end

  // Registered outputs follow the next state so a word and its status align
  always_ff @(posedge CLK or negedge RESETGN) begin
    if (!RESETGN) begin
      DATA_OUT <= IDLE_WORD;
      CHAR_OUT <= '1;
      RUNNING  <= 1'b0;
    end else if (state_next == ST_RUN) begin
      DATA_OUT <= prbs_word ^ {{(DATA_W-1){1'b0}}, inject};
      CHAR_OUT <= '0;
      RUNNING  <= 1'b1;
    end else begin
      DATA_OUT <= IDLE_WORD;
      CHAR_OUT <= '1;
      RUNNING  <= 1'b0;
    end
  end

  // Saturating count of PRBS words sent in the current run
  always_ff @(posedge CLK or negedge RESETGN) begin
    if (!RESETGN) begin
      WORD_CNT <= '0;
    end else if (run_start) begin
      WORD_CNT <= '0;
    end else if (state_next == ST_RUN && WORD_CNT != '1) begin
      WORD_CNT <= WORD_CNT + 32'd1;
    end
  end

`ifdef PRBS_ERR_INJECT_EN
  logic err_q;
  logic err_prev;

  // Only a rising edge seen while staying in RUN flips the next word
  assign inject = (state == ST_RUN) && (state_next == ST_RUN) && err_q && !err_prev;

  // ERROR_IN input stage plus previous value for edge detection
  always_ff @(posedge CLK or negedge RESETGN) begin
    if (!RESETGN) begin
      err_q    <= 1'b0;
      err_prev <= 1'b0;
    end else begin
      err_q    <= ERROR_IN;
      err_prev <= err_q;
    end
  end

  // Saturating count of injected errors in the current run
  always_ff @(posedge CLK or negedge RESETGN) begin
    if (!RESETGN) begin
      ERR_CNT <= '0;
    end else if (run_start) begin
      ERR_CNT <= '0;
    end else if (inject && ERR_CNT != '1) begin
      ERR_CNT <= ERR_CNT + 16'd1;
    end
  end
`else
  logic unused_err_in;

  assign unused_err_in = ERROR_IN;
  assign inject        = 1'b0;
  assign ERR_CNT       = '0;
`endif

endmodule

// File: tb/tb_prbs_gen_multi.sv
// Directed bench for prbs_gen_multi: two instances (16-bit and 32-bit words)
// share stimulus and are compared against a serial PRBS reference model.
module tb_prbs_gen_multi;

  localparam int PRE = 8;

  logic        clk = 1'b0;
  logic        resetgn;
  logic        start;
  logic [1:0]  mode;
  logic        error_in;

  logic [15:0] d16;
  logic [1:0]  c16;
  logic        r16;
  logic [31:0] wc16;
  logic [15:0] ec16;
  logic [31:0] d32;
  logic [3:0]  c32;
  logic        r32;
  logic [31:0] wc32;
  logic [15:0] ec32;

  int          vec_cnt  = 0;
  int          miss_cnt = 0;
  logic [30:0] s16;
  logic [30:0] s32;
  logic [1:0]  mdl_mode;
  logic        inj_exp;

  always #5 clk = ~clk;

  prbs_gen_multi #(.DATA_W(16), .PRE_LEN(PRE)) u16 (
    .CLK(clk), .RESETGN(resetgn), .START(start), .MODE(mode), .ERROR_IN(error_in),
    .DATA_OUT(d16), .CHAR_OUT(c16), .RUNNING(r16), .WORD_CNT(wc16), .ERR_CNT(ec16)
  );

  prbs_gen_multi #(.DATA_W(32), .PRE_LEN(PRE)) u32 (
    .CLK(clk), .RESETGN(resetgn), .START(start), .MODE(mode), .ERROR_IN(error_in),
    .DATA_OUT(d32), .CHAR_OUT(c32), .RUNNING(r32), .WORD_CNT(wc32), .ERR_CNT(ec32)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Serial reference: N-bit register, explicit mask, first bit into word[0]
  task automatic mdl_word(input int w, inout logic [30:0] s, output logic [31:0] word);
    int          n;
    int          t;
    logic [30:0] mask;
    logic        b;
    case (mdl_mode)
      2'd0:    begin n = 7;  t = 6;  mask = 31'h0000007F; end
      2'd1:    begin n = 15; t = 14; mask = 31'h00007FFF; end
      2'd2:    begin n = 23; t = 18; mask = 31'h007FFFFF; end
      default: begin n = 31; t = 28; mask = 31'h7FFFFFFF; end
    endcase
    word = '0;
    for (int i = 0; i < w; i++) begin
      b       = s[n-1] ^ s[t-1];
      word[i] = b;
      s       = ((s << 1) | {30'd0, b}) & mask;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_d16"},  d16,  16'hBC3C);
    chk({tag, "_c16"},  c16,  2'b11);
    chk({tag, "_r16"},  r16,  1'b0);
    chk({tag, "_wc16"}, wc16, 32'd0);
    chk({tag, "_ec16"}, ec16, 16'd0);
    chk({tag, "_d32"},  d32,  32'hBC3CBC3C);
    chk({tag, "_c32"},  c32,  4'hF);
    chk({tag, "_r32"},  r32,  1'b0);
    chk({tag, "_wc32"}, wc32, 32'd0);
    chk({tag, "_ec32"}, ec32, 16'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_d16"}, d16, 16'hBC3C);
    chk({tag, "_c16"}, c16, 2'b11);
    chk({tag, "_r16"}, r16, 1'b0);
    chk({tag, "_d32"}, d32, 32'hBC3CBC3C);
    chk({tag, "_c32"}, c32, 4'hF);
    chk({tag, "_r32"}, r32, 1'b0);
  endtask

  // One PRBS word on both instances; flip toggles expected bit 0
  task automatic step_check(input string tag, input logic flip);
    logic [31:0] w16;
    logic [31:0] w32;
    mdl_word(16, s16, w16);
    mdl_word(32, s32, w32);
    chk({tag, "_d16"}, d16, {16'd0, w16[15:1], w16[0] ^ flip});
    chk({tag, "_d32"}, d32, {w32[31:1], w32[0] ^ flip});
  endtask

  // START high, full preamble, first PRBS word
  task automatic run_start(input logic [1:0] m);
    mode     = m;
    mdl_mode = m;
    start    = 1'b1;
    s16      = '1;
    s32      = '1;
    tick();
    chk_idle("edge_n");
    for (int k = 1; k <= PRE; k++) begin
      tick();
      chk_idle("preamble");
    end
    tick();
    step_check("first", 1'b0);
    if (m == 2'd0) chk("first_3040", d16, 16'h3040);
    chk("first_c16",  c16,  2'b00);
    chk("first_c32",  c32,  4'h0);
    chk("first_r16",  r16,  1'b1);
    chk("first_r32",  r32,  1'b1);
    chk("first_wc16", wc16, 32'd1);
    chk("first_wc32", wc32, 32'd1);
    chk("first_ec16", ec16, 16'd0);
    chk("first_ec32", ec32, 16'd0);
  endtask

  // START low: one more word at edge m, idle at edge m+1, counters hold
  task automatic stop_run(input int words);
    start = 1'b0;
    tick();
    step_check("stop_m", 1'b0);
    tick();
    chk_idle("stop_m1");
    chk("stop_wc16", wc16, 32'(words + 1));
    tick();
    chk("hold_wc32", wc32, 32'(words + 1));
  endtask

  initial begin
`ifdef PRBS_ERR_INJECT_EN
    inj_exp = 1'b1;
`else
    inj_exp = 1'b0;
`endif
    resetgn  = 1'b0;
    start    = 1'b0;
    mode     = 2'd0;
    error_in = 1'b0;
    mdl_mode = 2'd0;
    s16      = '1;
    s32      = '1;
    #8;
    chk_reset("reset");
    tick();
    resetgn = 1'b1;
    repeat (3) tick();
    chk_idle("idle");

    // Rising edge of ERROR_IN outside RUN must be discarded
    error_in = 1'b1;
    repeat (2) tick();
    error_in = 1'b0;
    repeat (2) tick();

    for (int m = 0; m < 4; m++) begin
      run_start(2'(m));
      for (int i = 2; i <= 1000; i++) begin
        tick();
        step_check("word", 1'b0);
        if (m == 0 && i == 128) chk("period127", d16, 16'h3040);
        if (i == 500) mode = ~2'(m);
      end
      chk("wc16_1000", wc16, 32'd1000);
      chk("wc32_1000", wc32, 32'd1000);
      stop_run(1000);
    end

    // Restart: preamble repeats, seed word and counter restart
    run_start(2'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      step_check("rerun", 1'b0);
    end

    // Single error injection, then ERROR_IN held high
    error_in = 1'b1;
    tick();
    step_check("inj_k", 1'b0);
    tick();
    step_check("inj_k1", inj_exp);
    chk("inj_ec16", ec16, {15'd0, inj_exp});
    chk("inj_ec32", ec32, {15'd0, inj_exp});
    for (int i = 0; i < 20; i++) begin
      tick();
      step_check("inj_hold", 1'b0);
    end
    chk("hold_ec16", ec16, {15'd0, inj_exp});
    chk("inj_wc16", wc16, 32'd33);
    error_in = 1'b0;

    // Asynchronous reset mid-run, checked between clock edges
    tick();
    step_check("pre_rst", 1'b0);
    #2;
    resetgn = 1'b0;
    #1;
    chk_reset("async_rst");
    #20;
    resetgn = 1'b1;
    repeat (2) tick();
    chk_idle("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/prbs_gen_multi.md
# prbs_gen_multi

Parametrised multi-polynomial PRBS generator for the ROC serial link test path. It drives K28.5/K28.1 comma idle words while stopped, then a fixed-length comma preamble, then a parallel PRBS data stream. The polynomial (PRBS7/15/23/31) is selected at run start. Optional single-word error injection and word/error counters support link BER tests. It feeds the transceiver TX data/K-char inputs directly.

## Interface
- `DATA_W`, 16 — output word width in bits; must be a multiple of 16, range 16..64.
- `PRE_LEN`, 8 — number of preamble words, range 1..255.
- `CLK` input 1 — clock; all logic is on its rising edge.
- `RESETGN` input 1 — reset: asynchronous, active-low.
- `START` input 1 — level; high = run, low = return to idle.
- `MODE` input 2 — polynomial select: 0=PRBS7, 1=PRBS15, 2=PRBS23, 3=PRBS31.
- `ERROR_IN` input 1 — error-inject request; its rising edge is used.
- `DATA_OUT` output DATA_W — TX data word, registered.
- `CHAR_OUT` output DATA_W/8 — per-byte K-char flags, registered.
- `RUNNING` output 1 — high while in RUN, registered.
- `WORD_CNT` output 32 — PRBS words sent in the current run; saturates at 0xFFFF_FFFF.
- `ERR_CNT` output 16 — errors injected in the current run; saturates at 0xFFFF.

## Operation
- Idle word: 16'hBC3C (K28.5, K28.1) replicated DATA_W/16 times, with CHAR_OUT all ones.
- Input registers: START → start_q and ERROR_IN → err_q, one stage each. Reset value 0.
- States and transitions:
  - IDLE: outputs the idle word. Moves to PREAMBLE when start_q=1. MODE is latched into mode_q on this transition.
  - PREAMBLE: outputs the idle word for exactly PRE_LEN cycles. On entry, WORD_CNT and ERR_CNT clear, the LFSR reseeds to all ones and the preamble counter reloads. Moves to RUN after the last preamble cycle.
  - RUN: outputs DATA_W new PRBS bits per cycle with CHAR_OUT=0. RUNNING=1. WORD_CNT increments by 1 per word.
  - From any state, start_q=0 moves to IDLE on the next edge. Counters then hold their last values.
- LFSR is a Fibonacci register s[30:0]; only the low N bits are used.
  - (N, tap T): PRBS7 (7,6), PRBS15 (15,14), PRBS23 (23,18), PRBS31 (31,28).
  - One serial step: b = s[N-1] ^ s[T-1]; then s[N-1:0] <= {s[N-2:0], b}.
  - One clock performs DATA_W serial steps. DATA_OUT[0] is the first bit generated in that cycle; DATA_OUT[DATA_W-1] is the last.
- MODE changes outside the IDLE→PREAMBLE transition are ignored.
- Error injection (when compiled in): in RUN, err_q=1 while the previous err_q=0 flips DATA_OUT[0] of the next word only.
  - The LFSR sequence is unaffected.
  - ERR_CNT increments on the same edge.
  - Rising edges outside RUN are discarded.

## Timing
- Reset values:
  - DATA_OUT = idle word, CHAR_OUT all ones.
  - RUNNING=0, WORD_CNT=0, ERR_CNT=0.
  - State IDLE, LFSR all ones, mode_q=0.
- Reset asserted mid-run returns all of the above immediately (asynchronously).
- Start-up sequence, with START first sampled high at edge n:
  - Edge n+1: enters PREAMBLE.
  - Edges n+1 .. n+PRE_LEN: idle word.
  - Edge n+PRE_LEN+1: first PRBS word, RUNNING=1, WORD_CNT=1.
- Stop: START first sampled low at edge m → idle word and RUNNING=0 at edge m+1.
- Injection: ERROR_IN rising edge sampled at edge k → the flipped word appears at edge k+1.
- A restart always repeats the preamble and restarts the sequence from the seed.

## Configuration
- Macro `PRBS_ERR_INJECT_EN`.
  - Defined: the error injection described above is implemented, and ERR_CNT counts injected errors.
  - Undefined: ERROR_IN and err_q are unused, DATA_OUT is never modified, and ERR_CNT is tied to 0.

## Test plan
- Reset with DATA_W=16 → DATA_OUT=16'hBC3C, CHAR_OUT=2'b11, RUNNING=0, counters 0.
- DATA_W=16, PRE_LEN=8, MODE=0, START high at edge n → 8 words of BC3C/11, then at edge n+9 DATA_OUT=16'h3040, CHAR_OUT=00, RUNNING=1. The stream has period 127 bits when checked against a serial reference model.
- For each MODE with DATA_W=32 → the stream matches the serial reference model for 1000 words. MODE changed mid-run has no effect.
- With PRBS_ERR_INJECT_EN defined, one ERROR_IN rising edge in RUN → exactly one word differs from the model, only in bit 0, and ERR_CNT=1. Holding ERROR_IN high produces no further errors.
- START dropped mid-run, then raised again → the idle word appears one cycle after the sampled drop. The new run has a full preamble, restarts at the seed word, and WORD_CNT restarts at 1.
- RESETGN asserted asynchronously mid-run → all outputs return to reset values without waiting for a clock edge.
